// File: rtl/glyph_fetch_sched_if.sv
// Glyph ROM read port: the scheduler issues code/row reads, the ROM returns rows.
interface glyph_fetch_sched_if #(
  parameter int unsigned GLYPH_W = 20
) ();
  logic               rom_req;
  logic [3:0]         rom_code;
  logic [4:0]         rom_row;
  logic [GLYPH_W-1:0] rom_data;

  modport master (output rom_req, rom_code, rom_row, input rom_data);
  modport slave  (input rom_req, rom_code, rom_row, output rom_data);
endinterface

// File: rtl/glyph_fetch_sched.sv
// Shares one glyph ROM across all character slots: fetches the next scanline's
// glyph rows during horizontal blanking and commits them atomically at end of line.
module glyph_fetch_sched #(
  parameter int unsigned NUM_SLOTS = 7,
  parameter int unsigned GLYPH_W   = 20,
  parameter int unsigned GLYPH_H   = 32,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned V_TOP     = 250,
  parameter int unsigned START_H   = 786,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_TOTAL   = 522
) (
  input  logic                         clk_25MHz,
  input  logic                         rst,
  input  logic [9:0]                   hcount,
  input  logic [9:0]                   vcount,
  input  logic [4*NUM_SLOTS-1:0]       slot_code,
  glyph_fetch_sched_if.master          rom,
  output logic [GLYPH_W*NUM_SLOTS-1:0] glyph_rows,
  output logic                         row_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned   IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [9:0]    START_HC  = 10'(START_H);
  localparam logic [9:0]    COMMIT_HC = 10'(H_TOTAL - 1);
  localparam logic [9:0]    LAST_VC   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    BAND_LO   = 10'(V_TOP);
  localparam logic [9:0]    BAND_HI   = 10'(V_TOP + GLYPH_H);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [9:0]         next_v_c;
  logic               in_band_c;
  logic [4:0]         row_c;
  logic               start_c, commit_c, pending_c;
  logic               rom_req_q, rom_req_d;
  logic [3:0]         rom_code_q, rom_code_d;
  logic [4:0]         rom_row_q, rom_row_d;
  logic [IDX_W-1:0]   issue_idx_q, issue_idx_d, next_idx_c;
  logic [3:0]         snap_q   [NUM_SLOTS];
  logic [GLYPH_W-1:0] shadow_q [NUM_SLOTS];
  logic               band_q;
  logic [ROM_LAT-1:0] tag_v_q;
  logic [IDX_W-1:0]   tag_idx_q [ROM_LAT];

  assign rom.rom_req  = rom_req_q;
  assign rom.rom_code = rom_code_q;
  assign rom.rom_row  = rom_row_q;

  // Line being prepared is the one after vcount, wrapping at frame end.
  always_comb begin
    next_v_c  = (vcount == LAST_VC) ? 10'd0 : vcount + 10'd1;
    in_band_c = (next_v_c >= BAND_LO) && (next_v_c < BAND_HI);
    row_c     = 5'(next_v_c - BAND_LO);
  end

  // Any tag still travelling that is not the one emerging this cycle.
  always_comb begin
    pending_c = 1'b0;
    for (int k = 0; k < int'(ROM_LAT) - 1; k++) pending_c = pending_c | tag_v_q[k];
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rom_req_d   = 1'b0;
    rom_code_d  = rom_code_q;
    rom_row_d   = rom_row_q;
    issue_idx_d = issue_idx_q;
    next_idx_c  = issue_idx_q + IDX_W'(1);
    start_c     = 1'b0;
    commit_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hcount == START_HC) begin
          start_c = 1'b1;
          if (in_band_c) begin
            state_d     = S_ISSUE;
            rom_req_d   = 1'b1;
            rom_code_d  = slot_code[3:0];
            rom_row_d   = row_c;
            issue_idx_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (issue_idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          rom_req_d   = 1'b1;
          rom_code_d  = snap_q[next_idx_c];
          issue_idx_d = next_idx_c;
        end
      end
      S_DRAIN: if (!pending_c) state_d = S_DONE;
      default: ;
    endcase
    // End of line always returns to IDLE, whatever was in flight.
    if (hcount == COMMIT_HC) begin
      commit_c  = 1'b1;
      state_d   = S_IDLE;
      rom_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      rom_req_q   <= 1'b0;
      rom_code_q  <= '0;
      rom_row_q   <= '0;
      issue_idx_q <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      row_valid   <= 1'b0;
      glyph_rows  <= '0;
      band_q      <= 1'b0;
      tag_v_q     <= '0;
      for (int k = 0; k < int'(ROM_LAT); k++) tag_idx_q[k] <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        snap_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      rom_req_q   <= rom_req_d;
      rom_code_q  <= rom_code_d;
      rom_row_q   <= rom_row_d;
      issue_idx_q <= issue_idx_d;
      busy        <= (state_d == S_ISSUE) || (state_d == S_DRAIN);

      tag_v_q[0]   <= rom_req_q && !commit_c;
      tag_idx_q[0] <= issue_idx_q;
      for (int k = 1; k < int'(ROM_LAT); k++) begin
        tag_v_q[k]   <= tag_v_q[k-1] && !commit_c;
        tag_idx_q[k] <= tag_idx_q[k-1];
      end

      if (start_c) begin
        band_q <= in_band_c;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
          snap_q[i]   <= slot_code[4*i +: 4];
          shadow_q[i] <= '0;
        end
      end else if (tag_v_q[ROM_LAT-1] && !commit_c) begin
        shadow_q[tag_idx_q[ROM_LAT-1]] <= rom.rom_data;
      end

      if (commit_c) begin
        case (state_q)
          S_DONE: begin
            for (int i = 0; i < int'(NUM_SLOTS); i++)
              glyph_rows[i*GLYPH_W +: GLYPH_W] <= shadow_q[i];
            row_valid <= band_q;
          end
          S_ISSUE, S_DRAIN: begin
            row_valid <= 1'b0;
            overrun   <= 1'b1;
          end
          default: row_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/glyph_fetch_sched.md
# glyph_fetch_sched

Shared-glyph-ROM fetch scheduler for the VGA clock display, in the 25 MHz pixel domain. During each line's horizontal blanking it time-multiplexes one digit-glyph ROM across all character slots (hour, minute and second digits plus the two colon glyphs) for the *next* scanline. Fetched rows go into a shadow buffer and are committed atomically at end of line. This replaces one ROM instance per digit; the pixel writer reads `glyph_rows` directly.

## Interface
- `NUM_SLOTS`, 7: character slots fetched per line.
- `GLYPH_W`, 20: glyph row width in bits.
- `GLYPH_H`, 32: glyph height in lines (row index is 5 bits).
- `ROM_LAT`, 1: fixed ROM read latency in cycles, ≥1.
- `V_TOP`, 250: first display line of the glyph band.
- `START_H`, 786: hcount at which fetch starts.
- `H_TOTAL`, 800: pixels per line (hcount 0..H_TOTAL-1).
- `V_TOTAL`, 522: lines per frame (vcount 0..V_TOTAL-1).
- `clk_25MHz`  in  1  pixel clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `hcount`  in  10  horizontal pixel counter from the display counter.
- `vcount`  in  10  vertical line counter from the display counter.
- `slot_code`  in  4*NUM_SLOTS  glyph code per slot; slot i is bits [4i+3:4i].
- `rom_req`  out  1  ROM read strobe, one read per high cycle.
- `rom_code`  out  4  glyph code for the current read.
- `rom_row`  out  5  glyph row for the current read.
- `rom_data`  in  GLYPH_W  ROM row data, valid exactly ROM_LAT cycles after the matching `rom_req`.
- `glyph_rows`  out  GLYPH_W*NUM_SLOTS  committed rows; slot i is bits [i*GLYPH_W +: GLYPH_W], stored unmodified from `rom_data`.
- `row_valid`  out  1  committed rows belong to a line inside the glyph band.
- `busy`  out  1  fetch in progress (ISSUE or DRAIN).
- `overrun`  out  1  sticky: a fetch was unfinished at commit.

## Operation
- **next_v:** 0 if vcount == V_TOTAL-1, else vcount+1.
- **in_band:** V_TOP ≤ next_v < V_TOP+GLYPH_H.
- **row:** (next_v − V_TOP), truncated to 5 bits.
- **FSM states:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE → ISSUE:** when hcount == START_H and in_band. Same cycle: snapshot all `slot_code` into an internal register, latch row, clear the shadow buffer.
- **IDLE → DONE:** when hcount == START_H and not in_band. Shadow buffer is cleared and marked out-of-band; no ROM reads.
- **ISSUE:** one cycle per slot, in order i = 0..NUM_SLOTS-1.
  - `rom_req`=1, `rom_code`=snapshot code i, `rom_row`=latched row.
  - After slot NUM_SLOTS-1, go to DRAIN.
- **Tag pipeline:** ROM_LAT deep, carrying {valid, slot index}. When a valid tag emerges, write `rom_data` into shadow slot[index].
- **DRAIN → DONE:** once the tag pipeline is empty, i.e. the last return has been written.
- **Commit:** at hcount == H_TOTAL-1, every state then goes to IDLE.
  - DONE: `glyph_rows` ← shadow, `row_valid` ← in-band flag.
  - ISSUE/DRAIN: `glyph_rows` held, `row_valid` ← 0, `overrun` ← 1. In-flight tags are flushed so no late write lands.
  - IDLE (no fetch started, e.g. reset mid-line): `glyph_rows` held, `row_valid` ← 0.
- `slot_code` changes after the snapshot do not affect the current line.
- Codes are passed through unchecked; glyph content for codes 11..15 is defined by the ROM.

## Timing
- **Reset values:** `rom_req`, `rom_code`, `rom_row`, `glyph_rows`, `row_valid`, `busy`, `overrun` all 0. FSM in IDLE, tag pipeline and snapshot cleared.
- **Reset mid-fetch:** the fetch is abandoned and pending returns are discarded. The next START_H starts cleanly.
- **Outputs:** all registered. `busy` is high exactly during ISSUE and DRAIN.
- **ISSUE timing:** with defaults, the START_H edge enters ISSUE and `rom_req` is high on hcount 787..793 (7 cycles).
- **DONE timing:** with defaults, the final write lands at hcount 794 and DONE is reached at hcount 795.
- **Fetch duration:** NUM_SLOTS + ROM_LAT + 1 cycles from START_H.
- **Overrun bound:** overrun cannot occur while START_H + NUM_SLOTS + ROM_LAT + 1 < H_TOTAL-1.
- **Commit edge:** `glyph_rows` and `row_valid` update on the hcount == H_TOTAL-1 edge, so they are stable for the whole of the next line.
- **Frame wrap:** vcount == V_TOTAL-1 makes next_v = 0, which is out of band for the defaults.

## Test plan
- **Reset:** hold `rst` 3 cycles with arbitrary hcount/vcount → all outputs 0; no `rom_req` until the next START_H.
- **In-band fetch:** vcount=249, slot_code=0xA5A3210 (slot0=0 … slot6=0xA), hcount sweeps 786→799 → `rom_req` high 7 cycles, `rom_code` 0,1,2,3,A,5,A, `rom_row`=0; after commit `glyph_rows` match the ROM model and `row_valid`=1.
- **Out of band and wrap:** vcount=281 (next_v=282) and vcount=521 (next_v=0) → no `rom_req`; after commit `glyph_rows`=0 and `row_valid`=0.
- **Snapshot:** change `slot_code` at hcount 789 during an in-band fetch → the `rom_code` sequence and committed rows use the pre-change codes; the next line uses the new codes.
- **Overrun:** ROM_LAT=12 → at commit `overrun`=1 and sticky, `glyph_rows` unchanged, `row_valid`=0.
- **Reset mid-fetch:** pulse `rst` at hcount 789 → `busy`=0 and `rom_req`=0 next cycle, no late shadow write; the following line fetches and commits correctly.
